cart_mem_arbiter: RTL

- Sequences the single-port 64 KB cartridge memory (one synchronous BRAM) between two requesters.
  - The HPS ioctl download writer, which streams the ROM image in.
  - The cartridge bus of the console core, which reads ROM and reads/writes SuperChip RAM.
- Replaces direct dual-port access with a registered, arbitrated port.
- Applies backpressure to the HPS via ioctl_wait.
- Reports loaded image size and completion to the bankswitch logic.

---
 rtl/cart_mem_arbiter_pkg.sv | 25 ++
 rtl/cart_mem_arbiter_if.sv | 26 ++
 rtl/cart_load_buf.sv | 99 +++++++++
 rtl/cart_mem_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/cart_mem_arbiter_pkg.sv
// Shared state encoding, constants and size helper for the cartridge memory arbiter.
package cart_pkg;

  localparam int unsigned CART_ADDR_W   = 16;
  localparam logic [7:0]  CART_OPEN_BUS = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    LD_WR,
    CPU_RD,
    CPU_DATA,
    CPU_WR
  } arb_state_t;

  // Size after a strobe at addr_lo: max(cur, addr_lo+1), clamped to cap.
  function automatic logic [16:0] grow_size(input logic [16:0] cur,
                                            input logic [16:0] addr_lo,
                                            input logic [17:0] cap);
    logic [17:0] cand;
    cand = {1'b0, addr_lo} + 18'd1;
    if (cand > cap) cand = cap;
    grow_size = (cand > {1'b0, cur}) ? cand[16:0] : cur;
  endfunction

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// Cartridge bus (console side) and BRAM port bundles for cart_mem_arbiter.
interface cart_cpu_if #(
  parameter int unsigned ADDR_W = cart_pkg::CART_ADDR_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_a;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_do;
  logic              cpu_ack;

  modport master (output cpu_req, cpu_we, cpu_a, cpu_din, input  cpu_do, cpu_ack);
  modport slave  (input  cpu_req, cpu_we, cpu_a, cpu_din, output cpu_do, cpu_ack);
endinterface

interface cart_mem_if #(
  parameter int unsigned ADDR_W = cart_pkg::CART_ADDR_W
);
  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic [7:0]        mem_d;
  logic [7:0]        mem_q;

  modport master (output mem_a, mem_we, mem_d, input  mem_q);
  modport slave  (input  mem_a, mem_we, mem_d, output mem_q);
endinterface

// File: rtl/cart_load_buf.sv
// ioctl download holding register, wait/backpressure, size and completion tracking.
// Optional running byte checksum when CART_CHECKSUM_EN is defined.
module cart_load_buf
  import cart_pkg::*;
#(
  parameter int unsigned ADDR_W   = CART_ADDR_W,
  parameter int unsigned MAX_SIZE = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              take,
  input  logic              ld_busy,
  output logic              hold_full,
  output logic [ADDR_W-1:0] hold_addr,
  output logic [7:0]        hold_data,
  output logic              ioctl_wait,
  output logic [16:0]       rom_size,
  output logic              load_done
`ifdef CART_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam logic [17:0] SIZE_CAP = 18'(MAX_SIZE);

  logic dl_q;
  logic full;
  logic done_pend;
  logic rise;
  logic fall;
  logic strobe_ok;
  logic in_range;
  logic drained;

  assign hold_full  = full;
  assign ioctl_wait = full;

  always_comb begin
    rise      = ioctl_download & ~dl_q;
    fall      = ~ioctl_download & dl_q;
    // The rising edge empties the register, so a strobe in that same cycle is accepted.
    strobe_ok = ioctl_wr & ioctl_download & (~full | rise);
    in_range  = (ioctl_addr[24:16] == '0);
    drained   = ~full & ~ld_busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q      <= 1'b0;
      full      <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      rom_size  <= '0;
      done_pend <= 1'b0;
      load_done <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      load_done <= 1'b0;

      if (take || rise) full <= 1'b0;

      if (strobe_ok) begin
        rom_size <= grow_size(rise ? '0 : rom_size, ioctl_addr[16:0], SIZE_CAP);
        if (in_range) begin
          full      <= 1'b1;
          hold_addr <= ioctl_addr[ADDR_W-1:0];
          hold_data <= ioctl_dout;
        end
      end else if (rise) begin
        rom_size <= '0;
      end

      if (rise) begin
        done_pend <= 1'b0;
      end else if ((done_pend || fall) && drained) begin
        load_done <= 1'b1;
        done_pend <= 1'b0;
      end else if (fall) begin
        done_pend <= 1'b1;
      end
    end
  end

`ifdef CART_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || rise) begin
      checksum <= '0;
    end else if (take) begin
      checksum <= checksum + 16'(hold_data);
    end
  end
`endif

endmodule

// File: rtl/cart_mem_arbiter.sv
// Single-port cartridge BRAM arbiter: HPS ioctl loader vs. console cart bus.
// Build option CART_CHECKSUM_EN adds a checksum output of the loaded image.
module cart_mem_arbiter
  import cart_pkg::*;
#(
  parameter int unsigned ADDR_W   = CART_ADDR_W,
  parameter int unsigned MAX_SIZE = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  cart_cpu_if.slave   cpu,
  cart_mem_if.master  mem,
  output logic [16:0] rom_size,
  output logic        load_done,
  output logic        busy
`ifdef CART_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  arb_state_t        state;
  logic              take;
  logic              ld_busy;
  logic              hold_full;
  logic [ADDR_W-1:0] hold_addr;
  logic [7:0]        hold_data;

  // The holding byte is copied into the BRAM port registers on entry to LD_WR,
  // which frees the holding register a cycle early for the next strobe.
  assign take    = (state == IDLE) && hold_full;
  assign ld_busy = (state == LD_WR);

  cart_load_buf #(
    .ADDR_W   (ADDR_W),
    .MAX_SIZE (MAX_SIZE)
  ) u_load_buf (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .take           (take),
    .ld_busy        (ld_busy),
    .hold_full      (hold_full),
    .hold_addr      (hold_addr),
    .hold_data      (hold_data),
    .ioctl_wait     (ioctl_wait),
    .rom_size       (rom_size),
    .load_done      (load_done)
`ifdef CART_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mem.mem_a   <= '0;
      mem.mem_we  <= 1'b0;
      mem.mem_d   <= '0;
      cpu.cpu_do  <= CART_OPEN_BUS;
      cpu.cpu_ack <= 1'b0;
    end else begin
      mem.mem_we  <= 1'b0;
      cpu.cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_full) begin
            state      <= LD_WR;
            busy       <= 1'b1;
            mem.mem_a  <= hold_addr;
            mem.mem_d  <= hold_data;
            mem.mem_we <= 1'b1;
          end else if (cpu.cpu_req) begin
            if (ioctl_download) begin
              // The loader owns the memory while a download is active.
              cpu.cpu_ack <= 1'b1;
              cpu.cpu_do  <= CART_OPEN_BUS;
            end else if (cpu.cpu_we) begin
              state      <= CPU_WR;
              busy       <= 1'b1;
              mem.mem_a  <= cpu.cpu_a;
              mem.mem_d  <= cpu.cpu_din;
              mem.mem_we <= 1'b1;
            end else begin
              state     <= CPU_RD;
              busy      <= 1'b1;
              mem.mem_a <= cpu.cpu_a;
            end
          end
        end
        LD_WR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        CPU_RD: begin
          state <= CPU_DATA;
        end
        CPU_DATA: begin
          cpu.cpu_do  <= mem.mem_q;
          cpu.cpu_ack <= 1'b1;
          state       <= IDLE;
          busy        <= 1'b0;
        end
        CPU_WR: begin
          cpu.cpu_ack <= 1'b1;
          state       <= IDLE;
          busy        <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
